hello_scroll_gen: RTL and testbench



---
 rtl/hello_scroll_gen.sv | 82 ++++++++
 tb/tb_hello_scroll_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/hello_scroll_gen.sv
// hello_scroll_gen: marquee feeder scrolling "hello" across a 6-digit 7-segment display word (optional blink-on-pause via HELLO_SCROLL_BLINK_EN)
module hello_scroll_gen #(
  parameter int MSG_LEN  = 8,
  parameter int STEP_DIV = 500
) (
  input  logic        clk_1k,
  input  logic        rst_n,
  input  logic        en,
  input  logic        dir,
  input  logic        load,
  output logic [23:0] data_out,
  output logic [3:0]  pos,
  output logic        step
);
  localparam logic [3:0]  LAST = 4'(MSG_LEN - 1);
  localparam logic [15:0] TOP  = 16'(STEP_DIV - 1);
  localparam logic [4:0]  LEN  = 5'(MSG_LEN);

  function automatic logic [23:0] frame(input logic [3:0] p);
    logic [4:0] idx;
    frame = '0;
    for (int k = 0; k < 6; k++) begin
      idx = 5'(p) + 5'(k);
      if (idx >= LEN) idx = idx - LEN;
      frame[23-4*k -: 4] = idx < 5'd5 ? idx[3:0] : 4'd5;
    end
  endfunction

  logic [15:0] cnt, cnt_nx;
  logic [3:0]  pos_nx, pos_adv;
  logic [23:0] data_nx;
  logic        step_nx, wrap;

  assign wrap    = cnt == TOP;
  assign pos_adv = dir ? (pos == 4'd0 ? LAST : pos - 4'd1) : (pos == LAST ? 4'd0 : pos + 4'd1);

`ifdef HELLO_SCROLL_BLINK_EN
  logic blank, blank_nx, en_q, rise;
  assign rise = en && !en_q;
  // next state: cnt free-runs even while paused, each paused wrap toggles blanking
  always_comb begin
    cnt_nx   = (load || rise || wrap) ? 16'd0 : cnt + 16'd1;
    step_nx  = !load && !rise && en && wrap;
    pos_nx   = load ? 4'd0 : step_nx ? pos_adv : pos;
    blank_nx = (load || rise) ? 1'b0 : (!en && wrap) ? !blank : blank;
    data_nx  = blank_nx ? 24'h555555 : frame(pos_nx);
  end
  // blank flag and en history; en_q resets high so en already high at release is not a rising edge
  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      blank <= 1'b0;
      en_q  <= 1'b1;
    end else begin
      blank <= blank_nx;
      en_q  <= en;
    end
  end
`else
  // next state: cnt frozen while paused, advance pos on prescaler wrap
  always_comb begin
    cnt_nx  = load ? 16'd0 : !en ? cnt : wrap ? 16'd0 : cnt + 16'd1;
    step_nx = !load && en && wrap;
    pos_nx  = load ? 4'd0 : step_nx ? pos_adv : pos;
    data_nx = frame(pos_nx);
  end
`endif

  // data_out is loaded from the same next pos, so it changes on the same edge as pos
  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 16'd0;
      pos      <= 4'd0;
      step     <= 1'b0;
      data_out <= 24'h012345;
    end else begin
      cnt      <= cnt_nx;
      pos      <= pos_nx;
      step     <= step_nx;
      data_out <= data_nx;
    end
  end
endmodule

// File: tb/tb_hello_scroll_gen.sv
// tb_hello_scroll_gen: directed and randomized check of hello_scroll_gen against a cycle-count reference model
module tb_hello_scroll_gen;
  localparam int L = 8;
  localparam int D = 4;

  logic        clk_1k = 1'b0;
  logic        rst_n  = 1'b0;
  logic        en     = 1'b0;
  logic        dir    = 1'b0;
  logic        load   = 1'b0;
  logic [23:0] data_out;
  logic [3:0]  pos;
  logic        step;

  int checks = 0;
  int errors = 0;
  int msg[L];
  int m_pos = 0;
  int m_acc = 0;
  bit m_step = 1'b0;

  hello_scroll_gen #(.MSG_LEN(L), .STEP_DIV(D)) dut (
    .clk_1k(clk_1k), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
    .data_out(data_out), .pos(pos), .step(step)
  );

  always #5 clk_1k = ~clk_1k;

  function automatic logic [23:0] word(int p);
    logic [23:0] w = '0;
    for (int k = 0; k < 6; k++) w = (w << 4) | 24'(msg[(p + k) % L]);
    return w;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_acc  = 0;
    m_step = 1'b0;
  endtask

  task automatic compare(string tag);
    check({tag, ".pos"}, 32'(pos), 32'(m_pos));
    check({tag, ".step"}, 32'(step), 32'(m_step));
    check({tag, ".data"}, 32'(data_out), 32'(word(m_pos)));
  endtask

  // one clock: model sees the same inputs as the DUT at the edge; outputs are sampled at the following negedge
  task automatic tick();
    @(posedge clk_1k);
    if (load) model_reset();
    else if (en) begin
      m_acc++;
      m_step = (m_acc == D);
      if (m_step) begin
        m_acc = 0;
        m_pos = dir ? (m_pos + L - 1) % L : (m_pos + 1) % L;
      end
    end else m_step = 1'b0;
    @(negedge clk_1k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare("arst");
    @(negedge clk_1k);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < L; i++) msg[i] = i < 5 ? i : 5;
    @(negedge clk_1k);
    @(negedge clk_1k);
    compare("reset");
    check("reset_word", 32'(data_out), 32'h012345);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      compare("hold");
    end
    en = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      tick();
      compare("left");
      check("left_step", 32'(step), 32'(c % 4 == 0));
      if (c == 4)  check("left_p1", 32'(data_out), 32'h123455);
      if (c == 8)  check("left_p2", 32'(data_out), 32'h234555);
      if (c == 28) check("left_p7", 32'(data_out), 32'h501234);
      if (c == 32) check("left_wrap", 32'(data_out), 32'h012345);
    end
    tick();
    do_reset();
    dir = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      compare("right");
      if (c == 4) check("right_p7", 32'(data_out), 32'h501234);
      if (c == 8) check("right_p6", 32'(data_out), 32'h550123);
    end
    dir = 1'b0;
    do_reset();
    repeat (2) tick();
    en = 1'b0;
    repeat (10) tick();
    compare("paused");
    en = 1'b1;
    tick();
    check("resume_early", 32'(step), 32'd0);
    tick();
    check("resume_step", 32'(step), 32'd1);
    do_reset();
    repeat (3) tick();
    load = 1'b1;
    tick();
    compare("load");
    check("load_nostep", 32'(step), 32'd0);
    load = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("after_load_step", 32'(step), 32'(c == 4));
    end
    for (int c = 0; c < 3000; c++) begin
      en   = $urandom_range(0, 9) != 0;
      load = $urandom_range(0, 39) == 0;
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      if ($urandom_range(0, 299) == 0) do_reset();
      tick();
      compare("rnd");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
